// File: rtl/mem_responder_if.sv
// mem_responder_if: groups the CPU data port (A), the instruction port (B),
// the CPU step enable, the external single-port SRAM bus and the serial
// byte handshake into one bundle.
//   slave  : the responder side (mem_responder)
//   master : the environment side (CPU, SRAM device, serial link)
// Port A: addrA, ctrlA, wdataA -> rdataA.  Port B: addrB -> rdataB.
// SRAM: sram_addr/sram_dout/strobes out, sram_din in.
// Serial: tx_data/tx_valid out, tx_ready in; rx_data/rx_valid in.
interface mem_responder_if;
    logic [15:0] addrA;
    logic [1:0]  ctrlA;
    logic [15:0] wdataA;
    logic [15:0] rdataA;
    logic [15:0] addrB;
    logic [15:0] rdataB;
    logic        cpu_step;
    logic [15:0] sram_addr;
    logic [15:0] sram_dout;
    logic [15:0] sram_din;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;

    modport slave (
        input  addrA, ctrlA, wdataA, addrB, sram_din, tx_ready, rx_data, rx_valid,
        output rdataA, rdataB, cpu_step, sram_addr, sram_dout,
               sram_ce_n, sram_oe_n, sram_we_n, tx_data, tx_valid
    );

    modport master (
        output addrA, ctrlA, wdataA, addrB, sram_din, tx_ready, rx_data, rx_valid,
        input  rdataA, rdataB, cpu_step, sram_addr, sram_dout,
               sram_ce_n, sram_oe_n, sram_we_n, tx_data, tx_valid
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: time-multiplexes the CPU data port (A) and instruction
// port (B) onto one single-port SRAM with a two-phase sequencer. Phase A
// serves the data port, phase B the fetch; cpu_step is high during phase B
// so the CPU advances once per completed A+B pair.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active low
//   bus  - mem_responder_if.slave (CPU ports, SRAM bus, serial handshake)
// Optional feature, macro UART_MMIO_EN: port-A accesses to MMIO_DATA_ADDR /
// MMIO_STAT_ADDR go to a byte serial port instead of the SRAM. Without the
// macro those addresses are ordinary SRAM and the serial outputs are 0.
module mem_responder #(
    parameter logic [15:0] RESET_IR       = 16'h0800,
    parameter logic [15:0] MMIO_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] MMIO_STAT_ADDR = 16'hBF01
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} phase_e;

    phase_e      phase_q, phase_d;
    logic [15:0] rdataA_q, rdataA_d;
    logic [15:0] rdataB_q, rdataB_d;
    logic        rd_a, wr_a;
    logic        mmio_hit;
    logic [15:0] mmio_rdata;

    assign rd_a = (bus.ctrlA == 2'b01);
    assign wr_a = (bus.ctrlA == 2'b10);

`ifdef UART_MMIO_EN
    logic       tx_valid_q, tx_valid_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_full_q, rx_full_d;
    logic       ovr_q, ovr_d;
    logic       data_hit, stat_hit;
    logic       data_wr, data_rd, stat_rd;

    assign data_hit = (bus.addrA == MMIO_DATA_ADDR);
    assign stat_hit = (bus.addrA == MMIO_STAT_ADDR);
    assign mmio_hit = (rd_a || wr_a) && (data_hit || stat_hit);

    // Register side effects happen on the edge ending phase A, so each
    // CPU access acts exactly once per pair.
    assign data_wr = (phase_q == PH_A) && wr_a && data_hit;
    assign data_rd = (phase_q == PH_A) && rd_a && data_hit;
    assign stat_rd = (phase_q == PH_A) && rd_a && stat_hit;

    assign mmio_rdata = data_hit ? (rx_full_q ? {8'h00, rx_byte_q} : 16'h0000)
                                 : {13'b0, ovr_q, rx_full_q, ~tx_valid_q};

    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rx_byte_d  = rx_byte_q;
        rx_full_d  = rx_full_q;
        ovr_d      = ovr_q;

        // A write landing while a byte is still pending is dropped.
        if (tx_valid_q && bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end else if (data_wr && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = bus.wdataA[7:0];
        end

        if (data_rd) rx_full_d = 1'b0;
        if (stat_rd) ovr_d = 1'b0;

        // A byte arriving with the holding register freed this same cycle
        // is accepted; otherwise a full register drops it and flags overrun.
        if (bus.rx_valid) begin
            if (rx_full_q && !data_rd) begin
                ovr_d = 1'b1;
            end else begin
                rx_full_d = 1'b1;
                rx_byte_d = bus.rx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_full_q  <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_byte_q  <= rx_byte_d;
            rx_full_q  <= rx_full_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
`else
    logic unused_mmio;

    assign mmio_hit     = 1'b0;
    assign mmio_rdata   = 16'h0000;
    assign bus.tx_valid = 1'b0;
    assign bus.tx_data  = 8'h00;
    assign unused_mmio  = ^{bus.tx_ready, bus.rx_data, bus.rx_valid,
                            MMIO_DATA_ADDR, MMIO_STAT_ADDR};
`endif

    // Sequencer next state plus SRAM strobes. The strobes are a pure decode
    // of the registered phase and pair-stable CPU inputs, so they do not
    // glitch; rst forces them idle so an access cut by reset never writes.
    always_comb begin
        phase_d       = (phase_q == PH_A) ? PH_B : PH_A;
        rdataA_d      = rdataA_q;
        rdataB_d      = rdataB_q;
        bus.sram_addr = 16'h0000;
        bus.sram_dout = 16'h0000;
        bus.sram_ce_n = 1'b1;
        bus.sram_oe_n = 1'b1;
        bus.sram_we_n = 1'b1;
        bus.cpu_step  = 1'b0;

        if (rst) begin
            case (phase_q)
                PH_A: begin
                    bus.sram_addr = bus.addrA;
                    if (mmio_hit) begin
                        if (rd_a) rdataA_d = mmio_rdata;
                    end else if (rd_a) begin
                        bus.sram_ce_n = 1'b0;
                        bus.sram_oe_n = 1'b0;
                        rdataA_d      = bus.sram_din;
                    end else if (wr_a) begin
                        bus.sram_ce_n = 1'b0;
                        bus.sram_we_n = 1'b0;
                        bus.sram_dout = bus.wdataA;
                    end
                end
                PH_B: begin
                    bus.sram_addr = bus.addrB;
                    bus.sram_ce_n = 1'b0;
                    bus.sram_oe_n = 1'b0;
                    bus.cpu_step  = 1'b1;
                    rdataB_d      = bus.sram_din;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= PH_A;
            rdataA_q <= 16'h0000;
            rdataB_q <= RESET_IR;
        end else begin
            phase_q  <= phase_d;
            rdataA_q <= rdataA_d;
            rdataB_q <= rdataB_d;
        end
    end

    assign bus.rdataA = rdataA_q;
    assign bus.rdataB = rdataB_q;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam logic [15:0] DATA_A = 16'hBF00;
    localparam logic [15:0] STAT_A = 16'hBF01;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus();

    mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // SRAM device model, driven purely by the DUT strobes.
    logic [15:0] dev_mem [0:65535];
    // Reference memory, updated from the stimulus alone.
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_rdA;

    always_comb begin
        if (!bus.sram_ce_n && !bus.sram_oe_n) bus.sram_din = dev_mem[bus.sram_addr];
        else                                  bus.sram_din = 16'hDEAD;
    end

    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n) dev_mem[bus.sram_addr] <= bus.sram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic is_mmio(input logic [15:0] a);
`ifdef UART_MMIO_EN
        return (a == DATA_A) || (a == STAT_A);
`else
        return 1'b0;
`endif
    endfunction

    // One CPU pair. Called at the start of phase A; returns at the start of
    // the next phase A. mexp is the expected read data for MMIO reads.
    task automatic do_pair(input logic [1:0] c, input logic [15:0] aA, input logic [15:0] wd,
                           input logic [15:0] aB, input logic rxv, input logic [7:0] rxd,
                           input logic txr, input logic [15:0] mexp);
        logic acc, mm, rd, wr;
        logic [15:0] expA, expB;
        bus.ctrlA = c; bus.addrA = aA; bus.wdataA = wd; bus.addrB = aB;
        bus.rx_valid = rxv; bus.rx_data = rxd; bus.tx_ready = txr;
        rd  = (c == 2'b01);
        wr  = (c == 2'b10);
        acc = rd || wr;
        mm  = acc && is_mmio(aA);
        #1;
        chk("phA_addr", bus.sram_addr, aA);
        chk("phA_ce_n", bus.sram_ce_n, !(acc && !mm));
        chk("phA_oe_n", bus.sram_oe_n, !(rd && !mm));
        chk("phA_we_n", bus.sram_we_n, !(wr && !mm));
        if (wr && !mm) chk("phA_dout", bus.sram_dout, wd);
        chk("phA_step", bus.cpu_step, 1'b0);
        if (rd) expA = mm ? mexp : ref_mem[aA];
        else    expA = ref_rdA;
        if (wr && !mm) ref_mem[aA] = wd;
        expB = ref_mem[aB];
        @(posedge clk); #1;
        bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
        chk("phB_addr", bus.sram_addr, aB);
        chk("phB_ce_n", bus.sram_ce_n, 1'b0);
        chk("phB_oe_n", bus.sram_oe_n, 1'b0);
        chk("phB_we_n", bus.sram_we_n, 1'b1);
        chk("phB_step", bus.cpu_step, 1'b1);
        @(posedge clk); #1;
        chk("rdataA", bus.rdataA, expA);
        chk("rdataB", bus.rdataB, expB);
        ref_rdA = expA;
    endtask

    function automatic logic [15:0] rnd_addr();
        logic [15:0] a;
        a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 16'(i) ^ 16'h5A3C;
            ref_mem[i] = 16'(i) ^ 16'h5A3C;
        end
        ref_rdA = 16'h0000;
        bus.ctrlA = 2'b00; bus.addrA = 16'h0; bus.wdataA = 16'h0; bus.addrB = 16'h0;
        bus.tx_ready = 1'b0; bus.rx_data = 8'h0; bus.rx_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdataA", bus.rdataA, 16'h0000);
        chk("rst_rdataB", bus.rdataB, 16'h0800);
        chk("rst_ce_n", bus.sram_ce_n, 1'b1);
        chk("rst_oe_n", bus.sram_oe_n, 1'b1);
        chk("rst_we_n", bus.sram_we_n, 1'b1);
        chk("rst_addr", bus.sram_addr, 16'h0000);
        chk("rst_dout", bus.sram_dout, 16'h0000);
        chk("rst_step", bus.cpu_step, 1'b0);
        chk("rst_txv", bus.tx_valid, 1'b0);
        chk("rst_txd", bus.tx_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        // First pair: cpu_step rises in the 2nd clk after release
        do_pair(2'b00, 16'h0000, 16'h0000, 16'h0010, 1'b0, 8'h0, 1'b0, 16'h0);

        // Write then read back
        do_pair(2'b10, 16'h0040, 16'h1234, 16'h0011, 1'b0, 8'h0, 1'b0, 16'h0);
        do_pair(2'b01, 16'h0040, 16'h0000, 16'h0012, 1'b0, 8'h0, 1'b0, 16'h0);
        chk("wr_rd_1234", bus.rdataA, 16'h1234);

        // Same-pair hazard: A writes, B reads the same word
        do_pair(2'b10, 16'h0100, 16'hBEEF, 16'h0100, 1'b0, 8'h0, 1'b0, 16'h0);
        chk("hazard_beef", bus.rdataB, 16'hBEEF);

        // Reserved control: idle SRAM in phase A, rdataA holds
        do_pair(2'b11, 16'h0040, 16'h9999, 16'h0041, 1'b0, 8'h0, 1'b0, 16'h0);
        chk("ctrl11_hold", bus.rdataA, 16'h1234);

        // Top-of-memory address is ordinary
        do_pair(2'b10, 16'hFFFF, 16'hCAFE, 16'h0000, 1'b0, 8'h0, 1'b0, 16'h0);
        do_pair(2'b01, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 8'h0, 1'b0, 16'h0);

        // Reset mid-pair during a write: the write must not land
        bus.ctrlA = 2'b10; bus.addrA = 16'h0050; bus.wdataA = 16'h7777; bus.addrB = 16'h0051;
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_we_n", bus.sram_we_n, 1'b1);
        chk("midrst_rdataB", bus.rdataB, 16'h0800);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        ref_rdA = 16'h0000;
        do_pair(2'b01, 16'h0050, 16'h0000, 16'h0050, 1'b0, 8'h0, 1'b0, 16'h0);

`ifdef UART_MMIO_EN
        // TX: hold while not accepted, drop a second write, clear on ready
        do_pair(2'b10, DATA_A, 16'h0041, 16'h0020, 1'b0, 8'h0, 1'b0, 16'h0);
        chk("tx_valid_set", bus.tx_valid, 1'b1);
        chk("tx_data_41", bus.tx_data, 8'h41);
        do_pair(2'b00, 16'h0000, 16'h0000, 16'h0021, 1'b0, 8'h0, 1'b0, 16'h0);
        chk("tx_valid_hold", bus.tx_valid, 1'b1);
        do_pair(2'b10, DATA_A, 16'h0042, 16'h0022, 1'b0, 8'h0, 1'b0, 16'h0);
        chk("tx_drop", bus.tx_data, 8'h41);
        do_pair(2'b00, 16'h0000, 16'h0000, 16'h0023, 1'b0, 8'h0, 1'b1, 16'h0);
        chk("tx_valid_clr", bus.tx_valid, 1'b0);
        do_pair(2'b01, STAT_A, 16'h0000, 16'h0024, 1'b0, 8'h0, 1'b0, 16'h0001);

        // RX overrun with TX busy
        do_pair(2'b10, DATA_A, 16'h0043, 16'h0025, 1'b0, 8'h0, 1'b0, 16'h0);
        do_pair(2'b00, 16'h0000, 16'h0000, 16'h0026, 1'b1, 8'h55, 1'b0, 16'h0);
        do_pair(2'b00, 16'h0000, 16'h0000, 16'h0027, 1'b1, 8'h66, 1'b0, 16'h0);
        do_pair(2'b01, STAT_A, 16'h0000, 16'h0028, 1'b0, 8'h0, 1'b0, 16'h0006);
        do_pair(2'b01, DATA_A, 16'h0000, 16'h0029, 1'b0, 8'h0, 1'b0, 16'h0055);
        do_pair(2'b00, 16'h0000, 16'h0000, 16'h002A, 1'b0, 8'h0, 1'b1, 16'h0);
        do_pair(2'b01, STAT_A, 16'h0000, 16'h002B, 1'b0, 8'h0, 1'b0, 16'h0001);

        // RX byte arriving in the same cycle as a DATA read
        do_pair(2'b00, 16'h0000, 16'h0000, 16'h002C, 1'b1, 8'h77, 1'b0, 16'h0);
        do_pair(2'b01, DATA_A, 16'h0000, 16'h002D, 1'b1, 8'h88, 1'b0, 16'h0077);
        do_pair(2'b01, STAT_A, 16'h0000, 16'h002E, 1'b0, 8'h0, 1'b0, 16'h0003);
        do_pair(2'b01, DATA_A, 16'h0000, 16'h002F, 1'b0, 8'h0, 1'b0, 16'h0088);
        do_pair(2'b01, DATA_A, 16'h0000, 16'h0030, 1'b0, 8'h0, 1'b0, 16'h0000);
`else
        // MMIO addresses are plain SRAM; serial outputs stay 0
        do_pair(2'b10, DATA_A, 16'h1111, 16'h0030, 1'b1, 8'h5A, 1'b1, 16'h0);
        do_pair(2'b01, DATA_A, 16'h0000, STAT_A, 1'b0, 8'h0, 1'b0, 16'h0);
        chk("plain_bf00", bus.rdataA, 16'h1111);
        chk("tx_valid_tied", bus.tx_valid, 1'b0);
        chk("tx_data_tied", bus.tx_data, 8'h00);
`endif

        // Randomized pairs against the reference memory
        for (int i = 0; i < 200; i++) begin
            do_pair(2'($urandom_range(0, 3)), rnd_addr(), 16'($urandom), rnd_addr(),
                    1'b0, 8'h0, 1'b0, 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the pipelined CPU's two memory ports: port A (data, MEM stage: address, 2-bit control, write data, read data) and port B (instruction fetch: address, read data).
- Time-multiplexes both ports onto one external single-port SRAM with a two-phase sequencer.
- Issues a `cpu_step` enable so the CPU advances once per completed A+B pair.
- Optionally decodes a memory-mapped serial port (byte TX/RX handshake) on port A.

Parameters:
- RESET_IR, 16'h0800, value of `rdataB` after reset (NOP fetched before first real fetch).
- MMIO_DATA_ADDR, 16'hBF00, serial data register address.
- MMIO_STAT_ADDR, 16'hBF01, serial status register address.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- addrA  in  16  data-port address
- ctrlA  in  2  data-port control: 00 none, 01 read, 10 write, 11 treated as none
- wdataA  in  16  data-port write data
- rdataA  out  16  data-port read data
- addrB  in  16  instruction-port address
- rdataB  out  16  instruction-port read data
- cpu_step  out  1  CPU clock-enable, high for the cycle ending a pair
- sram_addr  out  16  SRAM address
- sram_dout  out  16  SRAM write data
- sram_din  in  16  SRAM read data
- sram_ce_n  out  1  SRAM chip enable, active low
- sram_oe_n  out  1  SRAM output enable, active low
- sram_we_n  out  1  SRAM write enable, active low
- tx_data  out  8  serial TX byte
- tx_valid  out  1  TX request
- tx_ready  in  1  TX accept
- rx_data  in  8  serial RX byte
- rx_valid  in  1  RX byte present, single-cycle strobe

Behaviour:
- Reset: clk and rst only; rst asynchronous, active low. When rst=0:
  - phase=PH_A.
  - rdataA=0, rdataB=RESET_IR, cpu_step=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_addr=0, sram_dout=0.
  - tx_valid=0, tx_data=0, RX holding empty, overrun=0.
- Reset asserted mid-pair aborts the access; no partial write completes after reset.
- Phase register toggles every clk: PH_A -> PH_B -> PH_A. CPU inputs are stable across a pair because the CPU only advances on `cpu_step`.
- PH_A:
  - sram_addr=addrA.
  - ctrlA=01: sram_ce_n=0, sram_oe_n=0; at the clock edge ending PH_A, rdataA<=sram_din.
  - ctrlA=10: sram_ce_n=0, sram_we_n=0, sram_dout=wdataA, sram_oe_n=1.
  - ctrlA=00 or 11: SRAM idle (ce_n=1); rdataA holds.
- PH_B:
  - sram_addr=addrB, sram_ce_n=0, sram_oe_n=0, sram_we_n=1.
  - At the clock edge ending PH_B, rdataB<=sram_din.
  - cpu_step=1 during PH_B only.
- Latency: read data is valid at the CPU edge that consumes it, exactly one pair (2 clk) after the address is presented.
- SRAM controls are glitch-free: a combinational decode of the registered phase and stable inputs. sram_we_n never goes low in PH_B.
- A read and a write to the same address in one pair (A writes, B reads): B returns the new value, since A is serviced first.
- Address wrap: 16-bit; 16'hFFFF is an ordinary location.

Optional Feature:
- Macro UART_MMIO_EN.
- Defined: port-A accesses to MMIO_DATA_ADDR and MMIO_STAT_ADDR never touch SRAM (ce_n=1 in that PH_A).
  - Write to DATA while TX is idle: tx_data<=wdataA[7:0], tx_valid<=1. tx_valid holds until the cycle tx_ready=1, then clears.
  - Write to DATA while tx_valid=1: the write is dropped.
  - Read DATA: rdataA={8'h00, held RX byte}; clears the holding register. Reading DATA when empty returns 16'h0000.
  - Read STAT: rdataA={13'b0, overrun, rx_full, ~tx_valid}; clears overrun.
  - rx_valid while holding is full: byte dropped, overrun<=1.
  - rx_valid in the same cycle as a DATA read: the new byte is loaded and rx_full stays 1.
- Undefined: those addresses are plain SRAM; tx_valid tied 0, tx_data tied 0, RX inputs ignored.

Test Plan:
- Reset: release rst -> rdataB=16'h0800, rdataA=0, all SRAM strobes high, first cpu_step on the 2nd clk after release.
- Write/read-back: ctrlA=10, addrA=16'h0040, wdataA=16'h1234; next pair ctrlA=01, addrA=16'h0040 -> sram_we_n low only in PH_A of pair 1; rdataA=16'h1234 after pair 2.
- Same-pair hazard: ctrlA=10, addrA=addrB=16'h0100, wdataA=16'hBEEF -> rdataB=16'hBEEF at the end of that pair.
- Idle/reserved control: ctrlA=11 -> sram_ce_n=1 throughout PH_A, rdataA unchanged, fetch still completes.
- MMIO TX (UART_MMIO_EN): write 16'h0041 to 16'hBF00 with tx_ready=0 for 3 clk -> tx_valid=1, tx_data=8'h41 held; second write 16'h0042 dropped; tx_ready pulse -> tx_valid=0; STAT read bit0=1.
- MMIO RX overrun (UART_MMIO_EN): rx_valid with 8'h55, then 8'h66 -> STAT=16'h0006; DATA read returns 16'h0055; next STAT=16'h0001.
